rgb_stream_driver: RTL

Parametrised serial LED-chain driver (WS2812-class one-wire NRZ) that generalises single-byte PWM encoding to streamed multi-word frames.
- Accepts LED words over a valid/ready handshake and serialises them MSB-first.
- Each bit is a fixed-period pulse whose high time is selected per bit value; the bit timer is runtime-configurable.
- Ends every frame with a programmable low latch gap, then pulses transmit_complete.
- Sits between a frame-buffer reader and the LED output pin.

---
 rtl/rgb_stream_driver_pkg.sv | 20 ++
 rtl/rgb_stream_driver_if.sv | 12 +
 rtl/rgb_stream_driver_bit.sv | 50 +++++
 rtl/rgb_stream_driver.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rgb_stream_driver_pkg.sv
// Shared definitions for the one-wire RGB LED stream driver: FSM encoding and
// reference timings for a 50 MHz clock.
package rgb_stream_driver_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_LATCH = 3'd4
    } rgb_state_e;

    // 50 MHz reference: 1.24 us bit, 0.8/0.4 us high times, 50 us or 300 us latch
    localparam int RGB_DEF_CLKMAX      = 62;
    localparam int RGB_DEF_HI1         = 40;
    localparam int RGB_DEF_HI0         = 20;
    localparam int RGB_DEF_LATCH_50US  = 2500;
    localparam int RGB_DEF_LATCH_300US = 15000;

endpackage

// File: rtl/rgb_stream_driver_if.sv
// LED word stream handshake between the frame-buffer reader and the driver.
interface rgb_stream_driver_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;

    modport master (output in_data, output in_valid, output in_last, input in_ready);
    modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/rgb_stream_driver_bit.sv
// Per-bit period counter: tracks position inside one bit and clamps the
// timing so every bit has at least one high and one low cycle.
module rgb_bit_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic [CNT_W-1:0] clkmax,
    input  logic [CNT_W-1:0] hi,
    output logic             phase_high,
    output logic             bit_done
);
    localparam int W1 = CNT_W + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] hi_c;

    always_comb begin
        per = (clkmax < CNT_W'(2)) ? CNT_W'(2) : clkmax;
        if (hi == '0)
            hi_c = CNT_W'(1);
        else if (hi >= per)
            hi_c = per - CNT_W'(1);
        else
            hi_c = hi;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (start)
            cnt_d = '0;
        else if (run)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // phase_high looks one cycle ahead: it says whether the next cycle is still high
    assign phase_high = (W1'(cnt_q) + W1'(1)) < W1'(hi_c);
    assign bit_done   = (cnt_q == per - CNT_W'(1));

endmodule

// File: rtl/rgb_stream_driver.sv
// WS2812-class NRZ serialiser: one holding register feeding a shift register,
// MSB-first bit encoding, and an end-of-frame latch gap.
module rgb_stream_driver
    import rgb_stream_driver_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int CNT_W   = 16,
    parameter int LATCH_W = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [CNT_W-1:0]   clkmax,
    input  logic [CNT_W-1:0]   hi_in_1,
    input  logic [CNT_W-1:0]   hi_in_0,
    input  logic [LATCH_W-1:0] latch_cycles,
    rgb_stream_driver_if.slave s_if,
    output logic               outpin,
    output logic               busy,
    output logic               nopulse,
    output logic               underrun,
    output logic               transmit_complete
);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_W - 1);

    rgb_state_e state_q, state_d;

    logic [DATA_W-1:0]  hold_q, shift_q, shift_d;
    logic               hold_valid_q, hold_valid_d;
    logic               hold_last_q;
    logic               cur_last_q, cur_last_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]   clkmax_s_q, clkmax_s_d;
    logic [CNT_W-1:0]   hi1_s_q, hi1_s_d;
    logic [CNT_W-1:0]   hi0_s_q, hi0_s_d;
    logic [LATCH_W-1:0] latch_cnt_q, latch_cnt_d;
    logic               outpin_q;
    logic               underrun_q, underrun_d;

    logic               accept, consume, to_latch;
    logic               t_start, t_run, phase_high, bit_done;
    logic [CNT_W-1:0]   hi_sel;

    assign accept  = s_if.in_valid && !hold_valid_q;
    assign t_run   = (state_q == ST_HIGH) || (state_q == ST_LOW);
    assign hi_sel  = shift_q[DATA_W-1] ? hi1_s_q : hi0_s_q;

    rgb_bit_timer #(.CNT_W(CNT_W)) u_bit_timer (
        .clk        (clk),
        .reset      (reset),
        .start      (t_start),
        .run        (t_run),
        .clkmax     (clkmax_s_q),
        .hi         (hi_sel),
        .phase_high (phase_high),
        .bit_done   (bit_done)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cur_last_d  = cur_last_q;
        bit_idx_d   = bit_idx_q;
        clkmax_s_d  = clkmax_s_q;
        hi1_s_d     = hi1_s_q;
        hi0_s_d     = hi0_s_q;
        latch_cnt_d = latch_cnt_q;
        underrun_d  = 1'b0;
        t_start     = 1'b0;
        consume     = 1'b0;
        to_latch    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en && hold_valid_q)
                    state_d = ST_LOAD;
            end
            ST_LOAD: begin
                consume    = 1'b1;
                shift_d    = hold_q;
                cur_last_d = hold_last_q;
                bit_idx_d  = IDX_MAX;
                clkmax_s_d = clkmax;
                hi1_s_d    = hi_in_1;
                hi0_s_d    = hi_in_0;
                t_start    = 1'b1;
                state_d    = ST_HIGH;
            end
            ST_HIGH: begin
                if (!phase_high)
                    state_d = ST_LOW;
            end
            ST_LOW: begin
                if (bit_done) begin
                    if (bit_idx_q != '0) begin
                        shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                        t_start   = 1'b1;
                        state_d   = ST_HIGH;
                    end else if (cur_last_q || !en) begin
                        to_latch = 1'b1;
                    end else if (hold_valid_q) begin
                        // chain straight into the next word, keeping the frame's timing
                        consume    = 1'b1;
                        shift_d    = hold_q;
                        cur_last_d = hold_last_q;
                        bit_idx_d  = IDX_MAX;
                        t_start    = 1'b1;
                        state_d    = ST_HIGH;
                    end else begin
                        underrun_d = 1'b1;
                        to_latch   = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                if (latch_cnt_q == '0)
                    state_d = ST_IDLE;
                else
                    latch_cnt_d = latch_cnt_q - LATCH_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        if (to_latch) begin
            state_d     = ST_LATCH;
            latch_cnt_d = (latch_cycles == '0) ? '0 : latch_cycles - LATCH_W'(1);
        end
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        if (consume)
            hold_valid_d = 1'b0;
        if (accept)
            hold_valid_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            hold_last_q  <= 1'b0;
            shift_q      <= '0;
            cur_last_q   <= 1'b0;
            bit_idx_q    <= '0;
            clkmax_s_q   <= '0;
            hi1_s_q      <= '0;
            hi0_s_q      <= '0;
            latch_cnt_q  <= '0;
            outpin_q     <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            if (accept) begin
                hold_q      <= s_if.in_data;
                hold_last_q <= s_if.in_last;
            end
            shift_q      <= shift_d;
            cur_last_q   <= cur_last_d;
            bit_idx_q    <= bit_idx_d;
            clkmax_s_q   <= clkmax_s_d;
            hi1_s_q      <= hi1_s_d;
            hi0_s_q      <= hi0_s_d;
            latch_cnt_q  <= latch_cnt_d;
            outpin_q     <= (state_d == ST_HIGH);
            underrun_q   <= underrun_d;
        end
    end

    assign s_if.in_ready     = !hold_valid_q;
    assign outpin            = outpin_q;
    assign busy              = (state_q != ST_IDLE);
    assign nopulse           = (state_q == ST_IDLE) || (state_q == ST_LATCH);
    assign underrun          = underrun_q;
    assign transmit_complete = (state_q == ST_LATCH) && (latch_cnt_q == '0);

endmodule
